ppm_capture: RTL and testbench

PPM_CAPTURE -- requirements
Module: ppm_capture

---
 rtl/ppm_capture.sv | 135 +++++++++++++
 tb/tb_ppm_capture.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/ppm_capture.sv
// ppm_capture: PPM frame decoder that measures falling-edge intervals and publishes complete frames.
// Build option: define PPM_CAPTURE_FILTER_EN to add a 3-sample glitch filter after the synchronizer.
module ppm_capture #(
  parameter int NUM_CH   = 6,
  parameter int CNT_W    = 32,
  parameter int SYNC_GAP = 400000
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic                    ppm_in,
  input  logic                    enable,
  output logic [NUM_CH*CNT_W-1:0] ch_data,
  output logic                    frame_valid,
  output logic [15:0]             frame_cnt,
  output logic [15:0]             err_cnt,
  output logic                    locked
);
  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  typedef enum logic [1:0] {WAIT_SYNC, ARMED, CAPTURE} state_t;
  state_t st_q, st_d;
  logic s1_q, s2_q, lvl_q, lvl, fall, gap;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] sh_q [NUM_CH];
  logic [CNT_W-1:0] sh_d [NUM_CH];
  logic [CNT_W-1:0] ch_q [NUM_CH];
  logic [CNT_W-1:0] ch_d [NUM_CH];
  logic fv_q, fv_d, lk_q, lk_d;
  logic [15:0] fc_q, fc_d, ec_q, ec_d;
`ifdef PPM_CAPTURE_FILTER_EN
  logic f1_q, f2_q;
  assign lvl = (s2_q == f1_q && s2_q == f2_q) ? s2_q : lvl_q;
  // history of synchronized samples; a level is accepted only once three agree
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      f1_q <= 1'b1;
      f2_q <= 1'b1;
    end else begin
      f1_q <= s2_q;
      f2_q <= f1_q;
    end
  end
`else
  assign lvl = s2_q;
`endif
  assign fall = !lvl && lvl_q;
  assign gap  = cnt_q >= CNT_W'(SYNC_GAP);
  // two-flop synchronizer plus the previously accepted level for edge detection
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      s1_q  <= 1'b1;
      s2_q  <= 1'b1;
      lvl_q <= 1'b1;
    end else begin
      s1_q  <= ppm_in;
      s2_q  <= s1_q;
      lvl_q <= lvl;
    end
  end
  // frame state, interval counter, shadow/output channels and status registers
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      st_q  <= WAIT_SYNC;
      cnt_q <= '0;
      idx_q <= '0;
      sh_q  <= '{default: '0};
      ch_q  <= '{default: '0};
      fv_q  <= 1'b0;
      fc_q  <= '0;
      ec_q  <= '0;
      lk_q  <= 1'b0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      sh_q  <= sh_d;
      ch_q  <= ch_d;
      fv_q  <= fv_d;
      fc_q  <= fc_d;
      ec_q  <= ec_d;
      lk_q  <= lk_d;
    end
  end
  // next-state: an edge always wins over the gap threshold; a commit uses the value stored this cycle
  always_comb begin
    st_d  = st_q;
    idx_d = idx_q;
    sh_d  = sh_q;
    ch_d  = ch_q;
    fv_d  = 1'b0;
    fc_d  = fc_q;
    ec_d  = ec_q;
    lk_d  = lk_q;
    cnt_d = !enable ? '0 : fall ? CNT_W'(1) : &cnt_q ? cnt_q : cnt_q + CNT_W'(1);
    if (!enable) begin
      st_d  = WAIT_SYNC;
      idx_d = '0;
    end else begin
      case (st_q)
        WAIT_SYNC: st_d = (!fall && gap) ? ARMED : WAIT_SYNC;
        ARMED: begin
          if (fall) begin
            idx_d = '0;
            st_d  = CAPTURE;
          end
        end
        CAPTURE: begin
          if (fall) begin
            sh_d[idx_q] = cnt_q;
            idx_d = idx_q + IW'(1);
            if (idx_q == IW'(NUM_CH - 1)) begin
              ch_d = sh_d;
              fv_d = 1'b1;
              fc_d = fc_q + 16'd1;
              lk_d = 1'b1;
              st_d = WAIT_SYNC;
            end
          end else if (gap) begin
            ec_d = &ec_q ? ec_q : ec_q + 16'd1;
            lk_d = 1'b0;
            st_d = ARMED;
          end
        end
        default: st_d = WAIT_SYNC;
      endcase
    end
  end
  for (genvar k = 0; k < NUM_CH; k++) begin : g_out
    assign ch_data[k*CNT_W +: CNT_W] = ch_q[k];
  end
  assign frame_valid = fv_q;
  assign frame_cnt   = fc_q;
  assign err_cnt     = ec_q;
  assign locked      = lk_q;
endmodule

// File: tb/tb_ppm_capture.sv
// tb_ppm_capture: directed and randomized PPM frames checked against an interval-level frame model.
module tb_ppm_capture;
  localparam int NUM_CH = 6, CNT_W = 32, SYNC_GAP = 1000, W = NUM_CH * CNT_W;
  typedef logic [W-1:0] vec_t;
`ifdef PPM_CAPTURE_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif
  logic ACLK = 1'b0, ARESETN = 1'b0, ppm_in = 1'b1, enable = 1'b0;
  logic [W-1:0] ch_data;
  logic frame_valid, locked;
  logic [15:0] frame_cnt, err_cnt;

  ppm_capture #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .SYNC_GAP(SYNC_GAP)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .ppm_in(ppm_in), .enable(enable),
    .ch_data(ch_data), .frame_valid(frame_valid), .frame_cnt(frame_cnt),
    .err_cnt(err_cnt), .locked(locked)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0, passed = 0, fails = 0;
  int fv_n = 0, bad = 0;
  logic fv_prev = 1'b0, rst_e = 1'b0;
  vec_t ch_prev = '0;
  vec_t e_ch = '0;
  logic [15:0] e_fc = '0, e_ec = '0;
  logic e_lk = 1'b0;
  int e_fv = 0;
  int sp [8];

  // ch_data may only move with frame_valid (or reset); frame_valid never lasts two cycles
  always @(posedge ACLK) rst_e <= !ARESETN;
  always @(negedge ACLK) begin
    if (frame_valid) fv_n++;
    if (fv_prev && frame_valid) bad++;
    if (ch_data !== ch_prev && !frame_valid && !rst_e) bad++;
    fv_prev = frame_valid;
    ch_prev = ch_data;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge ACLK);
      #1;
    end
  endtask

  task automatic check(input string tag, input vec_t obs, input vec_t exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // edges 0..k, edge i followed by sp[i] cycles; optional 2-cycle low glitch 50 cycles into channel gl
  task automatic burst(input int k, input int gl);
    for (int i = 0; i <= k; i++) begin
      ppm_in = 1'b0;
      tick(20);
      ppm_in = 1'b1;
      if (i == k) tick(40);
      else if (i == gl) begin
        tick(30);
        ppm_in = 1'b0;
        tick(2);
        ppm_in = 1'b1;
        tick(sp[i] - 52);
      end else tick(sp[i] - 20);
    end
  endtask

  // frame outcome from the intervals the receiver would see: NUM_CH of them commit, fewer is an error
  task automatic model(input int k, input int gl);
    int iv[$];
    for (int i = 0; i < k; i++) begin
      if (i == gl && !FILT) begin
        iv.push_back(50);
        iv.push_back(sp[i] - 50);
      end else iv.push_back(sp[i]);
    end
    if (iv.size() >= NUM_CH) begin
      for (int c = 0; c < NUM_CH; c++) e_ch[c*CNT_W +: CNT_W] = CNT_W'(iv[c]);
      e_fc = e_fc + 16'd1;
      e_fv++;
      e_lk = 1'b1;
    end else begin
      if (e_ec != 16'hFFFF) e_ec = e_ec + 16'd1;
      e_lk = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_ch"}, ch_data, e_ch);
    check({tag, "_fcnt"}, vec_t'(frame_cnt), vec_t'(e_fc));
    check({tag, "_ecnt"}, vec_t'(err_cnt), vec_t'(e_ec));
    check({tag, "_lock"}, vec_t'(locked), vec_t'(e_lk));
    check({tag, "_fvn"}, vec_t'(fv_n), vec_t'(e_fv));
  endtask

  task automatic set_sp(input int base, input int step);
    for (int i = 0; i < 8; i++) sp[i] = base + step * i;
  endtask

  initial begin
    tick(3);
    ARESETN = 1'b1;
    tick(1);
    check("rst_ch", ch_data, '0);
    check("rst_fv", vec_t'(frame_valid), '0);
    check_all("rst");
    enable = 1'b1;
    tick(5000);
    check_all("idle");
    set_sp(100, 50);
    burst(6, -1);
    model(6, -1);
    check("f1_const", ch_data, vec_t'({32'd350, 32'd300, 32'd250, 32'd200, 32'd150, 32'd100}));
    check_all("f1");
    tick(1100);
    burst(4, -1);
    tick(2000);
    model(4, -1);
    check_all("trunc");
    set_sp(110, 10);
    burst(6, -1);
    model(6, -1);
    check("f2_const", ch_data, vec_t'({32'd160, 32'd150, 32'd140, 32'd130, 32'd120, 32'd110}));
    check_all("f2");
    tick(1100);
    set_sp(200, 20);
    burst(2, -1);
    enable = 1'b0;
    tick(10);
    enable = 1'b1;
    burst(3, -1);
    tick(1100);
    check_all("endrop");
    burst(6, -1);
    model(6, -1);
    check_all("after_en");
    tick(1100);
    set_sp(100, 50);
    burst(6, 2);
    model(6, 2);
    check_all("glitch");
    tick(1100);
    burst(3, -1);
    ARESETN = 1'b0;
    tick(1);
    ARESETN = 1'b1;
    e_ch = '0;
    e_fc = '0;
    e_ec = '0;
    e_lk = 1'b0;
    check("midrst_fv", vec_t'(frame_valid), '0);
    check_all("midrst");
    burst(2, -1);
    tick(1100);
    check_all("post_rst");
    set_sp(130, 15);
    burst(6, -1);
    model(6, -1);
    check_all("rst_frame");
    tick(1100);
    for (int f = 0; f < 8; f++) begin
      int k;
      k = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NUM_CH - 1)) : NUM_CH;
      for (int i = 0; i < 8; i++) sp[i] = int'($urandom_range(30, 400));
      burst(k, -1);
      tick(1100);
      model(k, -1);
      check_all($sformatf("rnd%0d", f));
    end
    check("monitor", vec_t'(bad), '0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
